// File: rtl/rgb_lookup_arbiter.sv
// rgb_lookup_arbiter: round-robin sharing of one 8-entry colour-to-RGB lookup memory between
// two requesters (A, B). One lookup issued per cycle; a tag pipeline matched to the memory read
// latency steers each returning word back to the requester that issued it.
// Build option: define RGB_ROM_OUTREG_EN when the memory has its output register enabled
// (2-cycle read, 3-cycle end-to-end latency). Default is a 1-cycle read, 2-cycle latency.
module rgb_lookup_arbiter #(
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned RGB_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_a,
  input  logic [COLOUR_W-1:0] colour_a,
  output logic                ack_a,
  output logic                valid_a,
  output logic [RGB_W-1:0]    rgb_a,
  input  logic                req_b,
  input  logic [COLOUR_W-1:0] colour_b,
  output logic                ack_b,
  output logic                valid_b,
  output logic [RGB_W-1:0]    rgb_b,
  output logic                rom_en,
  output logic [COLOUR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]    rom_dout
);

`ifdef RGB_ROM_OUTREG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  // Priority pointer: 0 favours A, 1 favours B when both request.
  logic             prio_q;
  logic             grant_a, grant_b;
  // Tag pipeline: valid bit and requester id (0 = A, 1 = B) per memory read stage.
  logic [Lat-1:0]   tag_vld_q;
  logic [Lat-1:0]   tag_id_q;
  logic             retire_a, retire_b;
  logic             valid_a_q, valid_b_q;
  logic [RGB_W-1:0] rgb_a_q, rgb_b_q;

  // Grant decode; reset blocks any issue in the same cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      grant_a = req_a && (!req_b || !prio_q);
      grant_b = req_b && (!req_a ||  prio_q);
    end
  end

  assign ack_a    = grant_a;
  assign ack_b    = grant_b;
  assign rom_en   = grant_a | grant_b;
  assign rom_addr = grant_a ? colour_a : (grant_b ? colour_b : '0);

  // Pointer moves to the other requester after each grant, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (grant_a) begin
      prio_q <= 1'b1;
    end else if (grant_b) begin
      prio_q <= 1'b0;
    end
  end

  // Tag shift register tracking in-flight reads; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= rom_en;
      tag_id_q[0]  <= grant_b;
      for (int unsigned i = 1; i < Lat; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign retire_a = tag_vld_q[Lat-1] && !tag_id_q[Lat-1];
  assign retire_b = tag_vld_q[Lat-1] &&  tag_id_q[Lat-1];

  // Capture returning data into the owner's result register and pulse its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      rgb_a_q   <= '0;
      rgb_b_q   <= '0;
    end else begin
      valid_a_q <= retire_a;
      valid_b_q <= retire_b;
      if (retire_a) rgb_a_q <= rom_dout;
      if (retire_b) rgb_b_q <= rom_dout;
    end
  end

  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
  assign rgb_a   = rgb_a_q;
  assign rgb_b   = rgb_b_q;

endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// Testbench for rgb_lookup_arbiter: directed stimulus with a scoreboard. Each issued lookup
// pushes its expected RGB word and return cycle; a monitor pops on every valid pulse.
// Define RGB_ROM_OUTREG_EN for both bench and RTL to exercise the 3-cycle build.
module tb_rgb_lookup_arbiter;

`ifdef RGB_ROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  colour_a = '0, colour_b = '0;
  logic        ack_a, ack_b, valid_a, valid_b, rom_en;
  logic [23:0] rgb_a, rgb_b, rom_dout;
  logic [2:0]  rom_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  rgb_lookup_arbiter #(.COLOUR_W(3), .RGB_W(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .colour_a (colour_a),
    .ack_a    (ack_a),
    .valid_a  (valid_a),
    .rgb_a    (rgb_a),
    .req_b    (req_b),
    .colour_b (colour_b),
    .ack_b    (ack_b),
    .valid_b  (valid_b),
    .rgb_b    (rgb_b),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: entry n holds 24'h010101 * n, synchronous read with optional output register.
  logic [23:0] mem_s1 = '0, mem_s2 = '0;
  always @(posedge clk) begin
    mem_s1 <= rom_en ? 24'h010101 * {21'd0, rom_addr} : 24'd0;
    mem_s2 <= mem_s1;
  end
`ifdef RGB_ROM_OUTREG_EN
  assign rom_dout = mem_s2;
`else
  assign rom_dout = mem_s1;
`endif

  function automatic logic [23:0] rgbof(input logic [2:0] c);
    return 24'h010101 * {21'd0, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; g = expected grant (0 none, 1 A, 2 B), hand-computed by the caller.
  task automatic step(input logic ra, input logic [2:0] ca, input logic rb, input logic [2:0] cb,
                      input int g);
    req_a = ra; colour_a = ca; req_b = rb; colour_b = cb;
    @(negedge clk);
    chk("ack_a", 32'(ack_a), 32'(g == 1));
    chk("ack_b", 32'(ack_b), 32'(g == 2));
    chk("rom_en", 32'(rom_en), 32'(g != 0));
    chk("rom_addr", 32'(rom_addr), (g == 1) ? 32'(ca) : (g == 2) ? 32'(cb) : 32'd0);
    if (g == 1) q_a.push_back('{rgbof(ca), cyc + LAT + 1});
    if (g == 2) q_b.push_back('{rgbof(cb), cyc + LAT + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    chk({tag, "_valid_b"}, 32'(valid_b), 32'd0);
    chk({tag, "_rgb_a"}, 32'(rgb_a), 32'd0);
    chk({tag, "_rgb_b"}, 32'(rgb_b), 32'd0);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding lookup for that requester,
  // and no outstanding lookup may go past its due cycle without a pulse.
  always @(negedge clk) begin
    if (valid_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid_a_unexpected: got pulse rgb_a=%0h, expected none (cycle %0d)",
                 rgb_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("rgb_a", 32'(rgb_a), 32'(e_a.rgb));
        chk("valid_a_cycle", cyc, e_a.cyc);
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid_b_unexpected: got pulse rgb_b=%0h, expected none (cycle %0d)",
                 rgb_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("rgb_b", 32'(rgb_b), 32'(e_b.rgb));
        chk("valid_b_cycle", cyc, e_b.cyc);
      end
    end
    if (q_a.size() != 0 && cyc > q_a[0].cyc) begin
      checks++; errors++;
      $display("FAIL valid_a_missing: got no pulse, expected one at cycle %0d", q_a[0].cyc);
      void'(q_a.pop_front());
    end
    if (q_b.size() != 0 && cyc > q_b[0].cyc) begin
      checks++; errors++;
      $display("FAIL valid_b_missing: got no pulse, expected one at cycle %0d", q_b[0].cyc);
      void'(q_b.pop_front());
    end
  end

  initial begin
    // Reset: a pending request must not be acked while rst is high.
    rst = 1'b1;
    step(1'b1, 3'd4, 1'b1, 3'd5, 0);
    step(1'b0, 3'd0, 1'b0, 3'd0, 0);
    check_zero("reset");
    rst = 1'b0;

    // Single A request, colour 2; B side must stay quiet.
    step(1'b1, 3'd2, 1'b0, 3'd0, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);
    chk("single_rgb_b", 32'(rgb_b), 32'd0);
    chk("single_rgb_a_held", 32'(rgb_a), 32'h020202);

    // Fresh reset so the pointer starts at A, then both requesting continuously.
    rst = 1'b1;
    step(1'b0, 3'd0, 1'b0, 3'd0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 3'd1, 1'b1, 3'd5, (i % 2 == 0) ? 1 : 2);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);

    // Back-to-back A stream, colours 0..7; pointer ends on B.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 3'd0, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);

    // Ten idle cycles: nothing moves, pointer still on B afterwards.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'd0, 1'b0, 3'd0, 0);
      chk("idle_valid_a", 32'(valid_a), 32'd0);
      chk("idle_valid_b", 32'(valid_b), 32'd0);
    end
    step(1'b1, 3'd2, 1'b1, 3'd7, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);

    // Reset with one A lookup in flight: it must be discarded, pointer back to A.
    step(1'b1, 3'd6, 1'b0, 3'd0, 1);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    step(1'b1, 3'd3, 1'b1, 3'd4, 0);
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    check_zero("midreset");
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);
    step(1'b1, 3'd3, 1'b1, 3'd4, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 0);

    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
